// File: rtl/cd101_pkg.sv
// Shared definitions for the ADSR envelope block: state codes, default widths
// and the full-scale envelope constant.
package cd101_pkg;

    localparam int ENV_W_DEF  = 8;
    localparam int RATE_W_DEF = 4;

    localparam logic [ENV_W_DEF-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_env_tick_sync.sv
// Brings an asynchronous divided clock into the clk domain and turns each of
// its rising edges into a single-cycle pulse; reusable for any clkdiv output.
module tick_sync (
    input  logic clk,
    input  logic arstn,
    input  logic async_sig,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_sig;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign pulse = sync & ~sync_d;

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator stepped by a synchronized divided clock.
// Define ADSR_EXP_DECAY_EN for env-proportional (roughly exponential) decay and release.
module adsr_env
    import cd101_pkg::*;
#(
    parameter int ENV_W  = ENV_W_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              tick_in,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack,
    input  logic [RATE_W-1:0] decay,
    input  logic [RATE_W-1:0] release_rate,
    input  logic [RATE_W-1:0] sustain,
    output logic [ENV_W-1:0]  env,
    output logic [2:0]        state,
    output logic              active
);

    localparam int REPS = (ENV_W + RATE_W - 1) / RATE_W;
    localparam logic [ENV_W:0] MAX_X = {1'b0, {ENV_W{1'b1}}};
    localparam logic [ENV_W:0] ONE_X = {{ENV_W{1'b0}}, 1'b1};

    adsr_state_t st;
    logic        step;
    logic        gate_q;
    logic        gate_rise;

    logic [REPS*RATE_W-1:0] level_rep;
    logic [ENV_W-1:0]       level;
    logic [ENV_W:0]         env_x;
    logic [ENV_W:0]         att_sum;
    logic [ENV_W:0]         dec_inc;
    logic [ENV_W:0]         rel_inc;
    logic [ENV_W:0]         dec_next;
    logic [ENV_W:0]         rel_next;

    tick_sync u_tick_sync (
        .clk       (clk),
        .arstn     (arstn),
        .async_sig (tick_in),
        .pulse     (step)
    );

    // Sustain code replicated across the envelope width so code 15 maps to full scale.
    assign level_rep = {REPS{sustain}};
    assign level     = level_rep[ENV_W-1:0];
    assign gate_rise = gate & ~gate_q;

    // One extra bit of headroom so neither the attack add nor the decrements can wrap.
    always_comb begin
        env_x   = {1'b0, env};
        att_sum = env_x + (ENV_W+1)'(attack) + ONE_X;
`ifdef ADSR_EXP_DECAY_EN
        dec_inc = (env_x >> 3) + (ENV_W+1)'(decay) + ONE_X;
        rel_inc = (env_x >> 3) + (ENV_W+1)'(release_rate) + ONE_X;
`else
        dec_inc = (ENV_W+1)'(decay) + ONE_X;
        rel_inc = (ENV_W+1)'(release_rate) + ONE_X;
`endif
        dec_next = (env_x > dec_inc) ? env_x - dec_inc : '0;
        rel_next = (env_x > rel_inc) ? env_x - rel_inc : '0;
    end

    // Gate transitions take priority over a coincident step, which is then dropped.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            st     <= IDLE;
            env    <= '0;
            active <= 1'b0;
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate;
            if (gate_rise) begin
                st     <= ATTACK;
                active <= 1'b1;
            end else if (!gate && (st == ATTACK || st == DECAY || st == SUSTAIN)) begin
                st     <= RELEASE;
                active <= 1'b1;
            end else begin
                case (st)
                    IDLE: env <= '0;
                    ATTACK: begin
                        if (step) begin
                            if (att_sum >= MAX_X) begin
                                env <= MAX_X[ENV_W-1:0];
                                st  <= DECAY;
                            end else begin
                                env <= att_sum[ENV_W-1:0];
                            end
                        end
                    end
                    DECAY: begin
                        if (step) begin
                            if (dec_next <= {1'b0, level}) begin
                                env <= level;
                                st  <= SUSTAIN;
                            end else begin
                                env <= dec_next[ENV_W-1:0];
                            end
                        end
                    end
                    SUSTAIN: env <= level;
                    RELEASE: begin
                        if (step) begin
                            if (rel_next == '0) begin
                                env    <= '0;
                                st     <= IDLE;
                                active <= 1'b0;
                            end else begin
                                env <= rel_next[ENV_W-1:0];
                            end
                        end
                    end
                    default: begin
                        st     <= IDLE;
                        env    <= '0;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_adsr_env.sv
// Self-checking bench for adsr_env: directed phases plus randomized gate/rate
// traffic compared every cycle against an arithmetic envelope model.
module tb_adsr_env;

    logic       clk = 1'b0;
    logic       arstn;
    logic       tick_in;
    logic       gate;
    logic [3:0] attack;
    logic [3:0] decay;
    logic [3:0] release_rate;
    logic [3:0] sustain;
    logic [7:0] env;
    logic [2:0] state;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;

    int m_env   = 0;
    int m_st    = 0;
    bit m_gprev = 1'b0;
    int edge_cnt = 0;
    int step_q[$];

    bit tick_en   = 1'b0;
    int tick_left = 0;

    adsr_env dut (
        .clk          (clk),
        .arstn        (arstn),
        .tick_in      (tick_in),
        .gate         (gate),
        .attack       (attack),
        .decay        (decay),
        .release_rate (release_rate),
        .sustain      (sustain),
        .env          (env),
        .state        (state),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Envelope rules applied once per clk edge; 0..4 = idle/attack/decay/sustain/release.
    task automatic model_edge();
        bit step;
        bit rise;
        int lvl;
        int a_inc;
        int d_inc;
        int r_inc;
        int nv;
        step = 1'b0;
        if (step_q.size() > 0 && step_q[0] == edge_cnt) begin
            step = 1'b1;
            void'(step_q.pop_front());
        end
        rise  = gate && !m_gprev;
        lvl   = int'(sustain) * 17;
        a_inc = int'(attack) + 1;
`ifdef ADSR_EXP_DECAY_EN
        d_inc = m_env / 8 + int'(decay) + 1;
        r_inc = m_env / 8 + int'(release_rate) + 1;
`else
        d_inc = int'(decay) + 1;
        r_inc = int'(release_rate) + 1;
`endif
        if (rise) begin
            m_st = 1;
        end else if (!gate && m_st >= 1 && m_st <= 3) begin
            m_st = 4;
        end else begin
            case (m_st)
                0: m_env = 0;
                1: if (step) begin
                    m_env = m_env + a_inc;
                    if (m_env >= 255) begin
                        m_env = 255;
                        m_st  = 2;
                    end
                end
                2: if (step) begin
                    nv = m_env - d_inc;
                    if (nv <= lvl) begin
                        m_env = lvl;
                        m_st  = 3;
                    end else begin
                        m_env = nv;
                    end
                end
                3: m_env = lvl;
                4: if (step) begin
                    nv = m_env - r_inc;
                    if (nv <= 0) begin
                        m_env = 0;
                        m_st  = 0;
                    end else begin
                        m_env = nv;
                    end
                end
                default: m_st = 0;
            endcase
        end
        m_gprev = gate;
    endtask

    // One clk cycle: drive at negedge, advance the model at posedge, compare 1ns later.
    task automatic apply_stimulus(input logic g);
        @(negedge clk);
        gate = g;
        if (tick_en) begin
            if (tick_left > 1) begin
                tick_left--;
            end else if (tick_in == 1'b0) begin
                tick_in = 1'b1;
                step_q.push_back(edge_cnt + 3);
                tick_left = int'($urandom_range(2, 3));
            end else begin
                tick_in = 1'b0;
                tick_left = int'($urandom_range(2, 4));
            end
        end else begin
            tick_in   = 1'b0;
            tick_left = 0;
        end
        @(posedge clk);
        edge_cnt++;
        model_edge();
        #1;
        check_output("env", 32'(env), m_env);
        check_output("state", 32'(state), m_st);
        check_output("active", 32'(active), 32'(m_st != 0));
    endtask

    task automatic run_until_state(input logic g, input int target, input int limit, input string tag);
        int n = 0;
        while (m_st != target && n < limit) begin
            apply_stimulus(g);
            n++;
        end
        check_output(tag, 32'(state), target);
    endtask

    task automatic model_reset();
        m_env   = 0;
        m_st    = 0;
        m_gprev = 1'b0;
        step_q.delete();
    endtask

    initial begin
        int n;
        int saved;
        int gate_left;
        logic g;

        arstn        = 1'b0;
        gate         = 1'b0;
        tick_in      = 1'b0;
        attack       = 4'd15;
        decay        = 4'd3;
        sustain      = 4'd8;
        release_rate = 4'd0;
        model_reset();
        #12;
        check_output("rst_env", 32'(env), 0);
        check_output("rst_state", 32'(state), 0);
        check_output("rst_active", 32'(active), 0);
        @(posedge clk);
        #2 arstn = 1'b1;
        tick_en = 1'b1;

        // Full attack/decay/sustain/release cycle with the reference settings.
        run_until_state(1'b1, 2, 600, "to_decay");
        check_output("attack_peak", 32'(env), 255);
        run_until_state(1'b1, 3, 1200, "to_sustain");
        check_output("sustain_env", 32'(env), 136);
        sustain = 4'd4;
        apply_stimulus(1'b1);
        check_output("sustain_track", 32'(env), 68);
        sustain = 4'd8;
        apply_stimulus(1'b1);
        check_output("sustain_back", 32'(env), 136);
        run_until_state(1'b0, 0, 4000, "to_idle");
        check_output("idle_active", 32'(active), 0);

        // Retrigger from the middle of a release.
        run_until_state(1'b1, 3, 2000, "re_sustain");
        n = 0;
        while (m_env > 100 && n < 2000) begin
            apply_stimulus(1'b0);
            n++;
        end
        check_output("release_state", 32'(state), 4);
        saved = m_env;
        apply_stimulus(1'b1);
        check_output("retrig_state", 32'(state), 1);
        check_output("retrig_env", 32'(env), saved);

        // Gate rise landing on the same edge as a step.
        apply_stimulus(1'b0);
        apply_stimulus(1'b0);
        n = 0;
        while (!(step_q.size() > 0 && step_q[0] == edge_cnt + 1) && n < 50) begin
            apply_stimulus(1'b0);
            n++;
        end
        check_output("coinc_found", 32'(n < 50), 1);
        saved = m_env;
        apply_stimulus(1'b1);
        check_output("coinc_state", 32'(state), 1);
        check_output("coinc_env", 32'(env), saved);

        // Asynchronous abort mid-attack, with the gate already high at release.
        attack = 4'd2;
        repeat (20) apply_stimulus(1'b1);
        @(negedge clk);
        #2 arstn = 1'b0;
        tick_en = 1'b0;
        tick_in = 1'b0;
        model_reset();
        #1;
        check_output("abort_env", 32'(env), 0);
        check_output("abort_state", 32'(state), 0);
        check_output("abort_active", 32'(active), 0);
        gate = 1'b1;
        repeat (3) @(posedge clk);
        #2 arstn = 1'b1;
        tick_en = 1'b1;
        apply_stimulus(1'b1);
        check_output("gate_held_rise", 32'(state), 1);

        // Randomized gate timing, rates and sustain level.
        g = 1'b1;
        gate_left = 200;
        for (int i = 0; i < 6000; i++) begin
            if (gate_left <= 0) begin
                g = ~g;
                gate_left = int'($urandom_range(1, 300));
            end
            gate_left--;
            if ($urandom_range(0, 7) == 0) begin
                attack       = 4'($urandom_range(0, 15));
                decay        = 4'($urandom_range(0, 15));
                release_rate = 4'($urandom_range(0, 15));
                sustain      = 4'($urandom_range(0, 15));
            end
            apply_stimulus(g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
